// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel stream into the window generator and 3x3 window out toward sobel_edge
//  pixel_in/pixel_valid/pixel_ready : raster-order 8-bit pixel handshake
//  sobel_en/sobel_done              : window request / completion from sobel_edge
//  comp_matrix [r][c]               : r=2 top line, c=2 leftmost column
//  win_row/win_col                  : window centre coordinates
//  frame_done                       : one-cycle pulse after the last window of a frame
//  master = window generator, slave = pixel source plus sobel_edge
interface sobel_window_gen_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  logic [7:0]           pixel_in;
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic                 sobel_done;
  logic                 sobel_en;
  logic [2:0][2:0][7:0] comp_matrix;
  logic [RW-1:0]        win_row;
  logic [CW-1:0]        win_col;
  logic                 frame_done;
  modport master (
    input  pixel_in, pixel_valid, sobel_done,
    output pixel_ready, sobel_en, comp_matrix, win_row, win_col, frame_done
  );
  modport slave (
    output pixel_in, pixel_valid, sobel_done,
    input  pixel_ready, sobel_en, comp_matrix, win_row, win_col, frame_done
  );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: buffers two image lines and presents every interior 3x3 window to sobel_edge
//  clk : rising-edge clock
//  rst : asynchronous active-high reset
//  bus : sobel_window_gen_if.master (pixel handshake in, window/handshake out)
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic               clk,
  input logic               rst,
  sobel_window_gen_if.master bus
);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  typedef enum logic {ACCEPT, BUSY} state_t;
  state_t               r_state, w_next;
  logic [CW-1:0]        r_x;
  logic [RW-1:0]        r_y;
  logic [7:0]           r_lb0 [IMG_WIDTH];
  logic [7:0]           r_lb1 [IMG_WIDTH];
  logic [2:0][2:0][7:0] r_win;
  logic [RW-1:0]        r_row;
  logic [CW-1:0]        r_col;
  logic                 r_ready, r_en, r_fd, r_last;
  logic                 w_accept, w_win, w_done, w_x_end, w_y_end;
  logic                 w_ready_d, w_en_d, w_fd_d;
  // r_ready is only set after the first edge out of reset, so it alone qualifies acceptance
  always_comb begin
    w_accept = r_ready && bus.pixel_valid;
    w_win    = w_accept && r_x >= CW'(2) && r_y >= RW'(2);
    w_done   = r_state == BUSY && bus.sobel_done;
    w_x_end  = r_x == CW'(IMG_WIDTH - 1);
    w_y_end  = r_y == RW'(IMG_HEIGHT - 1);
  end
  always_comb w_next = r_state == ACCEPT ? (w_win ? BUSY : ACCEPT) : (w_done ? ACCEPT : BUSY);
  // handshake outputs are registered from the next state so they are 0 during reset
  always_comb begin
    w_ready_d = w_next == ACCEPT;
    w_en_d    = w_next == BUSY;
    w_fd_d    = w_done && r_last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ACCEPT;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_ready_d;
      r_en    <= w_en_d;
      r_fd    <= w_fd_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_win  <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_win[2] <= {r_win[2][1:0], r_lb1[r_x]};
      r_win[1] <= {r_win[1][1:0], r_lb0[r_x]};
      r_win[0] <= {r_win[0][1:0], bus.pixel_in};
      r_x      <= w_x_end ? '0 : r_x + 1'b1;
      if (w_x_end) r_y <= w_y_end ? '0 : r_y + 1'b1;
      if (w_win) begin
        r_row  <= r_y - 1'b1;
        r_col  <= r_x - 1'b1;
        r_last <= w_x_end && w_y_end;
      end
    end
  // line buffers need no reset: the x>=2, y>=2 guard never exposes their stale contents
  always_ff @(posedge clk)
    if (w_accept) begin
      r_lb1[r_x] <= r_lb0[r_x];
      r_lb0[r_x] <= bus.pixel_in;
    end
  assign bus.pixel_ready = r_ready;
  assign bus.sobel_en    = r_en;
  assign bus.frame_done  = r_fd;
  assign bus.comp_matrix = r_win;
  assign bus.win_row     = r_row;
  assign bus.win_col     = r_col;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: checks sobel_window_gen against a frame-array window model
module tb_sobel_window_gen;
  localparam int W = 4;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sobel_window_gen_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();
  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int win_cnt = 0;
  int px = 0;
  int py = 0;
  logic [7:0]           img [W*H];
  logic                 pending = 1'b0;
  logic [2:0][2:0][7:0] exp_m;
  logic [1:0]           exp_r, exp_c;
  logic                 exp_last;
  always @(posedge clk) if (bus.frame_done === 1'b1) fd_cnt++;
  task automatic push(input logic [7:0] p, input int gap);
    int n;
    bus.pixel_valid = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge clk);
    n = 0;
    while (bus.pixel_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.pixel_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_wait: pixel_ready=%b required 1", bus.pixel_ready);
    end
    bus.pixel_in = p;
    bus.pixel_valid = 1'b1;
    img[py*W+px] = p;
    pending = px >= 2 && py >= 2;
    if (pending) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) exp_m[r][c] = img[(py-r)*W+px-c];
      exp_r = 2'(py - 1);
      exp_c = 2'(px - 1);
      exp_last = px == W - 1 && py == H - 1;
      win_cnt++;
    end
    px = px == W - 1 ? 0 : px + 1;
    if (px == 0) py = py == H - 1 ? 0 : py + 1;
    @(posedge clk);
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    tests++;
    if ({bus.sobel_en, bus.pixel_ready} !== {pending, !pending}) begin
      fails++;
      $display("FAIL handshake: en/ready=%b%b required %b%b", bus.sobel_en, bus.pixel_ready, pending, !pending);
    end
    if (pending) begin
      tests++;
      if ({bus.comp_matrix, bus.win_row, bus.win_col} !== {exp_m, exp_r, exp_c}) begin
        fails++;
        $display("FAIL window: got %h row %0d col %0d, required %h row %0d col %0d",
                 bus.comp_matrix, bus.win_row, bus.win_col, exp_m, exp_r, exp_c);
      end
    end
  endtask
  task automatic complete(input int stall, input bit hold);
    for (int i = 0; i < stall; i++) begin
      if (hold) begin
        bus.pixel_in = 8'($urandom);
        bus.pixel_valid = 1'b1;
      end
      @(negedge clk);
      tests++;
      if ({bus.sobel_en, bus.pixel_ready, bus.comp_matrix, bus.win_row, bus.win_col} !==
          {1'b1, 1'b0, exp_m, exp_r, exp_c}) begin
        fails++;
        $display("FAIL stall_hold: en=%b ready=%b win=%h row %0d col %0d, required en=1 ready=0 win=%h row %0d col %0d",
                 bus.sobel_en, bus.pixel_ready, bus.comp_matrix, bus.win_row, bus.win_col, exp_m, exp_r, exp_c);
      end
    end
    bus.sobel_done = 1'b1;
    @(negedge clk);
    bus.sobel_done = 1'b0;
    bus.pixel_valid = 1'b0;
    tests++;
    if ({bus.sobel_en, bus.pixel_ready, bus.frame_done} !== {1'b0, 1'b1, exp_last}) begin
      fails++;
      $display("FAIL done: en/ready/frame_done=%b%b%b required 01%b",
               bus.sobel_en, bus.pixel_ready, bus.frame_done, exp_last);
    end
    pending = 1'b0;
  endtask
  task automatic send(input logic [7:0] p, input int gap, input int stall, input bit hold);
    push(p, gap);
    if (pending) complete(stall, hold);
  endtask
  task automatic do_reset;
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({bus.sobel_en, bus.pixel_ready, bus.frame_done, bus.comp_matrix, bus.win_row, bus.win_col} !== '0) begin
      fails++;
      $display("FAIL async_reset: en=%b ready=%b fd=%b win=%h row %0d col %0d, required all 0",
               bus.sobel_en, bus.pixel_ready, bus.frame_done, bus.comp_matrix, bus.win_row, bus.win_col);
    end
    bus.sobel_done = 1'b0;
    bus.pixel_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    px = 0;
    py = 0;
    pending = 1'b0;
    #1;
    tests++;
    if (bus.pixel_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: pixel_ready=%b required 0", bus.pixel_ready);
    end
    @(negedge clk);
    tests++;
    if (bus.pixel_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_edge: pixel_ready=%b required 1", bus.pixel_ready);
    end
  endtask
  task automatic test_reset;
    #1;
    tests++;
    if ({bus.sobel_en, bus.pixel_ready, bus.frame_done, bus.comp_matrix, bus.win_row, bus.win_col} !== '0) begin
      fails++;
      $display("FAIL powerup_reset: en=%b ready=%b fd=%b win=%h, required all 0",
               bus.sobel_en, bus.pixel_ready, bus.frame_done, bus.comp_matrix);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.pixel_ready !== 1'b1) begin
      fails++;
      $display("FAIL release_ready: pixel_ready=%b required 1", bus.pixel_ready);
    end
    for (int i = 0; i < 3; i++) send(8'(i + 50), 0, 0, 1'b0);
    do_reset;
  endtask
  task automatic test_first_window;
    logic [2:0][2:0][7:0] lit;
    lit = '{'{8'd0, 8'd1, 8'd2}, '{8'd4, 8'd5, 8'd6}, '{8'd8, 8'd9, 8'd10}};
    for (int i = 0; i < 10; i++) send(8'(i), 0, 0, 1'b0);
    push(8'd10, 0);
    tests++;
    if ({bus.comp_matrix, bus.win_row, bus.win_col} !== {lit, 2'd1, 2'd1}) begin
      fails++;
      $display("FAIL first_window: got %h row %0d col %0d, required %h row 1 col 1",
               bus.comp_matrix, bus.win_row, bus.win_col, lit);
    end
    complete(0, 1'b0);
  endtask
  task automatic test_stream;
    logic [2:0][2:0][7:0] lits [3];
    logic [3:0] pos [3];
    int k, fd0;
    lits[0] = '{'{8'd1, 8'd2, 8'd3}, '{8'd5, 8'd6, 8'd7}, '{8'd9, 8'd10, 8'd11}};
    lits[1] = '{'{8'd4, 8'd5, 8'd6}, '{8'd8, 8'd9, 8'd10}, '{8'd12, 8'd13, 8'd14}};
    lits[2] = '{'{8'd5, 8'd6, 8'd7}, '{8'd9, 8'd10, 8'd11}, '{8'd13, 8'd14, 8'd15}};
    pos[0] = 4'b0110;
    pos[1] = 4'b1001;
    pos[2] = 4'b1010;
    k = 0;
    fd0 = fd_cnt;
    for (int i = 11; i < 16; i++) begin
      push(8'(i), 0);
      if (pending) begin
        tests++;
        if (k > 2 || {bus.comp_matrix, bus.win_row, bus.win_col} !== {lits[k], pos[k]}) begin
          fails++;
          $display("FAIL stream_window%0d: got %h rc %b%b, required %h rc %b",
                   k, bus.comp_matrix, bus.win_row, bus.win_col, lits[k%3], pos[k%3]);
        end
        k++;
        complete(0, 1'b0);
      end
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (k != 3 || fd_cnt - fd0 != 1) begin
      fails++;
      $display("FAIL stream_counts: windows=%0d frame_done=%0d, required 3 and 1", k, fd_cnt - fd0);
    end
  endtask
  task automatic test_stall;
    for (int i = 0; i < 16; i++) send(8'(i), 0, i == 10 ? 5 : 0, 1'b1);
  endtask
  task automatic test_back_to_back;
    logic [2:0][2:0][7:0] lit;
    lit = '{'{8'd100, 8'd101, 8'd102}, '{8'd104, 8'd105, 8'd106}, '{8'd108, 8'd109, 8'd110}};
    for (int i = 0; i < 16; i++) begin
      push(8'(100 + i), 0);
      if (i == 10) begin
        tests++;
        if (bus.comp_matrix !== lit) begin
          fails++;
          $display("FAIL frame2_first: got %h required %h", bus.comp_matrix, lit);
        end
      end
      if (pending) complete(0, 1'b0);
    end
  endtask
  task automatic test_reset_busy;
    int w0, fd0;
    for (int i = 0; i < 11; i++) send(8'(i), 0, 0, 1'b0);
    push(8'd11, 0);
    do_reset;
    w0 = win_cnt;
    fd0 = fd_cnt;
    for (int i = 0; i < 16; i++) send(8'(i), 0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (win_cnt - w0 != 4 || fd_cnt - fd0 != 1) begin
      fails++;
      $display("FAIL restart_counts: windows=%0d frame_done=%0d, required 4 and 1", win_cnt - w0, fd_cnt - fd0);
    end
  endtask
  task automatic test_random;
    int fd0;
    fd0 = fd_cnt;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < W * H; i++)
        send(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (fd_cnt - fd0 != 3) begin
      fails++;
      $display("FAIL random_frames: frame_done=%0d required 3", fd_cnt - fd0);
    end
  endtask
  initial begin
    bus.pixel_in = 8'd0;
    bus.pixel_valid = 1'b0;
    bus.sobel_done = 1'b0;
    test_reset;
    test_first_window;
    test_stream;
    test_stall;
    test_back_to_back;
    test_reset_busy;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
